// File: rtl/enemy_formation_pkg.sv
// Shared types and constants for the enemy formation controller.
package enemy_formation_pkg;

  localparam int unsigned FRAC_BITS = 6;
  localparam int unsigned POS_W     = 18;
  localparam int unsigned SCREEN_H  = 480;

  typedef logic signed [POS_W-1:0] fixpos_t;

  typedef enum logic [1:0] {MOVE, DROP, HALT} form_state_t;

endpackage

// File: rtl/formation_extent.sv
// Combinational extent of the live formation: outermost live columns,
// lowest live row and number of live enemies.
module formation_extent #(
  parameter int COLS = 4,
  parameter int ROWS = 2
) (
  input  logic [ROWS*COLS-1:0] aliveMask,
  output logic [2:0]           leftCol,
  output logic [2:0]           rightCol,
  output logic [1:0]           lowRow,
  output logic [4:0]           aliveCount
);

  logic [COLS-1:0] col_any;
  logic [ROWS-1:0] row_any;

  always_comb begin
    col_any    = '0;
    row_any    = '0;
    leftCol    = '0;
    rightCol   = '0;
    lowRow     = '0;
    aliveCount = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        col_any[c] = col_any[c] | aliveMask[r*COLS+c];
        row_any[r] = row_any[r] | aliveMask[r*COLS+c];
        aliveCount = aliveCount + 5'(aliveMask[r*COLS+c]);
      end
    end
    // descending scan leaves the lowest live column
    for (int c = COLS-1; c >= 0; c--) begin
      if (col_any[c]) leftCol = 3'(c);
    end
    for (int c = 0; c < COLS; c++) begin
      if (col_any[c]) rightCol = 3'(c);
    end
    for (int r = 0; r < ROWS; r++) begin
      if (row_any[r]) lowRow = 2'(r);
    end
  end

endmodule

// File: rtl/enemy_formation_ctrl.sv
// Moves a ROWS x COLS enemy grid as one formation, draws it and removes hit enemies.
// Optional wave respawn after a full clear: define ENEMY_RESPAWN_EN.
module enemy_formation_ctrl
  import enemy_formation_pkg::*;
#(
  parameter int COLS         = 4,
  parameter int ROWS         = 2,
  parameter int OBJ_W        = 30,
  parameter int OBJ_H        = 30,
  parameter int PITCH_X      = 40,
  parameter int PITCH_Y      = 40,
  parameter int INITIAL_X    = 100,
  parameter int INITIAL_Y    = 60,
  parameter int BASE_SPEED   = 64,
  parameter int SPEED_STEP   = 16,
  parameter int DROP_Y       = 16,
  parameter int SCREEN_W     = 640,
  parameter int BOTTOM_LIMIT = 400
`ifdef ENEMY_RESPAWN_EN
  , parameter int RESPAWN_FRAMES = 60
`endif
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic [10:0]          pixelX,
  input  logic [10:0]          pixelY,
  input  logic                 shotHit,
  output logic                 drawingRequest,
  output logic [10:0]          offsetX,
  output logic [10:0]          offsetY,
  output logic [4:0]           hitIndex,
  output logic [10:0]          formationX,
  output logic [10:0]          formationY,
  output logic [ROWS*COLS-1:0] aliveMask,
  output logic [4:0]           aliveCount,
  output logic                 allDead,
  output logic                 reachedBottom
);

  localparam int      NUM    = ROWS * COLS;
  localparam fixpos_t INIT_X = fixpos_t'(INITIAL_X <<< FRAC_BITS);

  form_state_t        state_q, state_d;
  fixpos_t            x_q, x_d;
  logic [10:0]        y_q, y_d;
  logic               dir_q, dir_d;
  logic [NUM-1:0]     alive_q, alive_d;
  logic [4:0]         cnt_q;
  logic               all_dead_q;
  logic               reached_q, reached_d;

`ifdef ENEMY_RESPAWN_EN
  localparam int unsigned CNT_W = $clog2(RESPAWN_FRAMES + 1);
  logic               armed_q, armed_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [3:0]         wave_q, wave_d;
`endif

  logic [2:0]         left_col, right_col;
  logic [1:0]         low_row;
  logic [4:0]         pop_cnt;
  logic               all_dead_c;

  formation_extent #(.COLS(COLS), .ROWS(ROWS)) u_extent (
    .aliveMask  (alive_q),
    .leftCol    (left_col),
    .rightCol   (right_col),
    .lowRow     (low_row),
    .aliveCount (pop_cnt)
  );

  assign all_dead_c    = (alive_q == '0);
  assign formationX    = 11'(x_q >>> FRAC_BITS);
  assign formationY    = y_q;
  assign aliveMask     = alive_q;
  assign aliveCount    = cnt_q;
  assign allDead       = all_dead_q;
  assign reachedBottom = reached_q;

  // Draw path: locate the cell under the pixel with compare chains.
  logic signed [12:0] fx, fy, dx, dy, rem_x, rem_y;
  logic [2:0]         col;
  logic [1:0]         row;
  logic [4:0]         idx;
  logic               in_box, cell_alive, draw_c;

  assign fx = 13'(x_q >>> FRAC_BITS);
  assign fy = {2'b00, y_q};
  assign dx = $signed({2'b00, pixelX}) - fx;
  assign dy = $signed({2'b00, pixelY}) - fy;

  always_comb begin
    col        = '0;
    row        = '0;
    rem_x      = dx;
    rem_y      = dy;
    cell_alive = 1'b0;
    for (int c = 1; c < COLS; c++) begin
      if (dx >= 13'(c * PITCH_X)) begin
        col   = 3'(c);
        rem_x = dx - 13'(c * PITCH_X);
      end
    end
    for (int r = 1; r < ROWS; r++) begin
      if (dy >= 13'(r * PITCH_Y)) begin
        row   = 2'(r);
        rem_y = dy - 13'(r * PITCH_Y);
      end
    end
    idx    = 5'(int'(row) * COLS + int'(col));
    in_box = !dx[12] && !dy[12] &&
             (dx < 13'(COLS * PITCH_X)) && (dy < 13'(ROWS * PITCH_Y)) &&
             (rem_x < 13'(OBJ_W)) && (rem_y < 13'(OBJ_H));
    for (int i = 0; i < NUM; i++) begin
      if (idx == 5'(i)) cell_alive = alive_q[i];
    end
    draw_c = in_box && cell_alive;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      drawingRequest <= 1'b0;
      offsetX        <= '0;
      offsetY        <= '0;
      hitIndex       <= '0;
    end else begin
      drawingRequest <= draw_c;
      offsetX        <= draw_c ? 11'(rem_x) : '0;
      offsetY        <= draw_c ? 11'(rem_y) : '0;
      hitIndex       <= draw_c ? idx : '0;
    end
  end

  // Candidate step; speed follows the registered live count.
  logic signed [31:0] wave_bonus, cand_px;
  fixpos_t            speed, cand;
  logic               hit_edge;

`ifdef ENEMY_RESPAWN_EN
  assign wave_bonus = SPEED_STEP * int'(wave_q);
`else
  assign wave_bonus = '0;
`endif
  assign speed    = fixpos_t'(BASE_SPEED + SPEED_STEP * (NUM - int'(cnt_q)) + wave_bonus);
  assign cand     = dir_q ? (x_q - speed) : (x_q + speed);
  assign cand_px  = 32'(cand >>> FRAC_BITS);
  assign hit_edge = (cand_px + int'(left_col) * PITCH_X < 0) ||
                    (cand_px + int'(right_col) * PITCH_X + OBJ_W > SCREEN_W);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dir_d     = dir_q;
    alive_d   = alive_q;
    reached_d = reached_q;
`ifdef ENEMY_RESPAWN_EN
    armed_d     = armed_q;
    frame_cnt_d = frame_cnt_q;
    wave_d      = wave_q;
`endif
    if (shotHit && drawingRequest) begin
      for (int i = 0; i < NUM; i++) begin
        if (hitIndex == 5'(i)) alive_d[i] = 1'b0;
      end
    end
    if (startOfFrame) begin
      if (state_q != HALT && all_dead_c) begin
        state_d = HALT;
`ifdef ENEMY_RESPAWN_EN
        armed_d     = 1'b1;
        frame_cnt_d = '0;
`endif
      end else begin
        case (state_q)
          MOVE: begin
            if (hit_edge) begin
              dir_d   = ~dir_q;
              state_d = DROP;
            end else begin
              x_d = cand;
            end
          end
          DROP: begin
            y_d = y_q + 11'(DROP_Y);
            if (int'(y_d) + int'(low_row) * PITCH_Y + OBJ_H >= BOTTOM_LIMIT) begin
              reached_d = 1'b1;
              state_d   = HALT;
            end else begin
              state_d = MOVE;
            end
          end
          HALT: begin
`ifdef ENEMY_RESPAWN_EN
            // only a cleared wave is armed; a bottom halt stays put
            if (armed_q) begin
              if (frame_cnt_q == CNT_W'(RESPAWN_FRAMES - 1)) begin
                alive_d     = '1;
                x_d         = INIT_X;
                y_d         = 11'(INITIAL_Y);
                dir_d       = 1'b0;
                armed_d     = 1'b0;
                frame_cnt_d = '0;
                state_d     = MOVE;
                if (wave_q != 4'd8) wave_d = wave_q + 4'd1;
              end else begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
              end
            end
`endif
          end
          default: state_d = HALT;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= MOVE;
      x_q        <= INIT_X;
      y_q        <= 11'(INITIAL_Y);
      dir_q      <= 1'b0;
      alive_q    <= '1;
      cnt_q      <= 5'(NUM);
      all_dead_q <= 1'b0;
      reached_q  <= 1'b0;
`ifdef ENEMY_RESPAWN_EN
      armed_q     <= 1'b0;
      frame_cnt_q <= '0;
      wave_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dir_q      <= dir_d;
      alive_q    <= alive_d;
      cnt_q      <= pop_cnt;
      all_dead_q <= all_dead_c;
      reached_q  <= reached_d;
`ifdef ENEMY_RESPAWN_EN
      armed_q     <= armed_d;
      frame_cnt_q <= frame_cnt_d;
      wave_q      <= wave_d;
`endif
    end
  end

endmodule

// File: tb/tb_enemy_formation_ctrl.sv
// Scoreboard bench for enemy_formation_ctrl: draw and movement expectations
// come from a behavioural formation model using plain division.
module tb_enemy_formation_ctrl;
  import enemy_formation_pkg::*;

  logic        clk = 1'b0;
  logic        resetN, startOfFrame, shotHit;
  logic [10:0] pixelX, pixelY;
  logic        drawingRequest, allDead, reachedBottom;
  logic [10:0] offsetX, offsetY, formationX, formationY;
  logic [4:0]  hitIndex, aliveCount;
  logic [7:0]  aliveMask;

  always #5 clk = ~clk;

  enemy_formation_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .shotHit(shotHit),
    .drawingRequest(drawingRequest), .offsetX(offsetX), .offsetY(offsetY),
    .hitIndex(hitIndex), .formationX(formationX), .formationY(formationY),
    .aliveMask(aliveMask), .aliveCount(aliveCount), .allDead(allDead),
    .reachedBottom(reachedBottom)
  );

  typedef struct packed {
    logic        draw;
    logic [4:0]  idx;
    logic [10:0] ox;
    logic [10:0] oy;
  } draw_exp_t;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
  } pos_exp_t;

  draw_exp_t q_draw[$];
  pos_exp_t  q_pos[$];
  int        checks = 0;
  int        errors = 0;

  // behavioural formation model (x in 1/64 px, st: 0 move, 1 drop, 2 halt)
  int         mx, my, mdir, mst, mwave;
  logic [7:0] mm;
  logic       mreached, mbounce;
`ifdef ENEMY_RESPAWN_EN
  logic       marmed;
  int         mhcnt;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int floor64(input int v);
    if (v >= 0) return v / 64;
    return -((-v + 63) / 64);
  endfunction

  function automatic draw_exp_t exp_draw(input int px, input int py);
    draw_exp_t e;
    int dx, dy, c, r;
    e  = '0;
    dx = px - floor64(mx);
    dy = py - my;
    if (dx >= 0 && dy >= 0) begin
      c = dx / 40;
      r = dy / 40;
      if (c < 4 && r < 2 && (dx % 40) < 30 && (dy % 40) < 30 && mm[r*4+c]) begin
        e.draw = 1'b1;
        e.idx  = 5'(r * 4 + c);
        e.ox   = 11'(dx % 40);
        e.oy   = 11'(dy % 40);
      end
    end
    return e;
  endfunction

  task automatic model_reset();
    mx = 6400; my = 60; mdir = 1; mst = 0; mwave = 0;
    mm = 8'hFF; mreached = 1'b0; mbounce = 1'b0;
`ifdef ENEMY_RESPAWN_EN
    marmed = 1'b0; mhcnt = 0;
`endif
  endtask

  task automatic model_step();
    int lc, rc, lr, sp, cand, cpx;
    lc = 3; rc = 0; lr = 0;
    for (int i = 0; i < 8; i++) begin
      if (mm[i]) begin
        if (i % 4 < lc) lc = i % 4;
        if (i % 4 > rc) rc = i % 4;
        if (i / 4 > lr) lr = i / 4;
      end
    end
    mbounce = 1'b0;
    if (mst == 2) begin
`ifdef ENEMY_RESPAWN_EN
      if (marmed) begin
        mhcnt++;
        if (mhcnt == 60) begin
          mm = 8'hFF; mx = 6400; my = 60; mdir = 1; mst = 0;
          marmed = 1'b0; mhcnt = 0;
          if (mwave < 8) mwave++;
        end
      end
`endif
    end else if (mm == 8'h00) begin
      mst = 2;
`ifdef ENEMY_RESPAWN_EN
      marmed = 1'b1; mhcnt = 0;
`endif
    end else if (mst == 0) begin
      sp   = 64 + 16 * (8 - $countones(mm)) + 16 * mwave;
      cand = mx + mdir * sp;
      cpx  = floor64(cand);
      if (cpx + lc * 40 < 0 || cpx + rc * 40 + 30 > 640) begin
        mdir = -mdir; mst = 1; mbounce = 1'b1;
      end else begin
        mx = cand;
      end
    end else begin
      my = my + 16;
      if (my + lr * 40 + 30 >= 400) begin
        mreached = 1'b1; mst = 2;
      end else begin
        mst = 0;
      end
    end
  endtask

  task automatic do_reset();
    resetN = 1'b0; startOfFrame = 1'b0; shotHit = 1'b0; pixelX = '0; pixelY = '0;
    model_reset();
    q_draw.delete(); q_pos.delete();
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
  endtask

  task automatic drive_px(input int px, input int py);
    draw_exp_t e;
    pixelX = 11'(px); pixelY = 11'(py);
    q_draw.push_back(exp_draw(px, py));
    @(negedge clk);
    e = q_draw.pop_front();
    check("draw_req", 32'(drawingRequest), 32'(e.draw));
    check("offset_x", 32'(offsetX), 32'(e.ox));
    check("offset_y", 32'(offsetY), 32'(e.oy));
    if (e.draw) check("hit_index", 32'(hitIndex), 32'(e.idx));
  endtask

  task automatic frame();
    pos_exp_t p;
    startOfFrame = 1'b1;
    model_step();
    q_pos.push_back(pos_exp_t'{x: 11'(floor64(mx)), y: 11'(my)});
    @(negedge clk);
    startOfFrame = 1'b0;
    p = q_pos.pop_front();
    check("frame_x", 32'(formationX), 32'(p.x));
    check("frame_y", 32'(formationY), 32'(p.y));
    repeat (2) @(negedge clk);
  endtask

  task automatic shoot(input int px, input int py, input bit sof);
    draw_exp_t e;
    pos_exp_t  p;
    e = exp_draw(px, py);
    drive_px(px, py);
    shotHit = 1'b1; pixelX = '0; pixelY = 11'(SCREEN_H - 1);
    if (sof) begin
      startOfFrame = 1'b1;
      model_step();
      q_pos.push_back(pos_exp_t'{x: 11'(floor64(mx)), y: 11'(my)});
    end
    if (e.draw) mm[e.idx] = 1'b0;
    @(negedge clk);
    shotHit = 1'b0; startOfFrame = 1'b0;
    if (sof) begin
      p = q_pos.pop_front();
      check("sof_kill_x", 32'(formationX), 32'(p.x));
    end
    check("kill_mask", 32'(aliveMask), 32'(mm));
    @(negedge clk);
    check("kill_count", 32'(aliveCount), 32'($countones(mm)));
  endtask

  task automatic shoot_cell(input int i, input bit sof);
    shoot(floor64(mx) + (i % 4) * 40 + 2, my + (i / 4) * 40 + 2, sof);
  endtask

  task automatic run_to_bounce(input int max_frames, input int exp_x);
    int n;
    n = 0;
    do begin
      frame();
      n++;
    end while (!mbounce && n < max_frames);
    if (mbounce) check("bounce_x", 32'(formationX), 32'(exp_x));
    else check("bounce_timeout", 32'(n), 32'(0));
  endtask

  initial begin
    int n;
    do_reset();
    // reset values
    check("rst_draw", 32'(drawingRequest), 32'(0));
    check("rst_offx", 32'(offsetX), 32'(0));
    check("rst_offy", 32'(offsetY), 32'(0));
    check("rst_hitidx", 32'(hitIndex), 32'(0));
    check("rst_bottom", 32'(reachedBottom), 32'(0));
    check("rst_alldead", 32'(allDead), 32'(0));
    check("rst_mask", 32'(aliveMask), 32'(8'hFF));
    check("rst_count", 32'(aliveCount), 32'(8));
    check("rst_x", 32'(formationX), 32'(100));
    check("rst_y", 32'(formationY), 32'(60));

    frame();
    check("first_step_x", 32'(formationX), 32'(101));

    // draw path: cell origin, gap, interior of cell 5, random pixels
    drive_px(101, 60);
    drive_px(136, 60);
    drive_px(146, 105);
    check("cell5_offx", 32'(offsetX), 32'(5));
    for (int i = 0; i < 40; i++)
      drive_px(80 + int'($urandom_range(0, 200)), 40 + int'($urandom_range(0, 120)));
    for (int i = 0; i < 10; i++)
      drive_px(int'($urandom_range(0, 639)), int'($urandom_range(0, SCREEN_H - 1)));

    // kills, an ignored shot, and a kill landing with startOfFrame
    shoot(146, 105, 1'b0);
    check("mask_df", 32'(aliveMask), 32'(8'hDF));
    drive_px(146, 105);
    shoot(136, 60, 1'b0);
    repeat (4) frame();
    shoot_cell(0, 1'b1);
    repeat (3) frame();

    // asynchronous reset mid-frame
    @(negedge clk);
    startOfFrame = 1'b1;
    #2 resetN = 1'b0;
    #1;
    check("async_mask", 32'(aliveMask), 32'(8'hFF));
    check("async_x", 32'(formationX), 32'(100));
    check("async_draw", 32'(drawingRequest), 32'(0));
    do_reset();

    // right-edge bounce with the full formation
    run_to_bounce(500, 490);
    frame();
    check("drop_y", 32'(formationY), 32'(76));
    frame();
    check("x_dec", 32'(formationX < 11'd490), 32'(1));

    // narrower formation bounces later, then runs down to the bottom
    do_reset();
    shoot_cell(3, 1'b0);
    shoot_cell(7, 1'b0);
    run_to_bounce(400, 530);
    n = 0;
    while (!mreached && n < 9000) begin
      frame();
      n++;
    end
    check("bottom_flag", 32'(reachedBottom), 32'(1));
    check("bottom_y", 32'(formationY), 32'(332));
    repeat (5) frame();
    foreach (mm[i]) if (mm[i]) shoot_cell(i, 1'b0);
    repeat (70) frame();
    check("bottom_mask", 32'(aliveMask), 32'(0));
    check("bottom_alldead", 32'(allDead), 32'(1));
    check("bottom_sticky", 32'(reachedBottom), 32'(1));

    // clear the wave at the start position
    do_reset();
    for (int i = 0; i < 8; i++) shoot_cell(i, 1'b0);
    check("clear_alldead", 32'(allDead), 32'(1));
    frame();
    repeat (60) frame();
`ifdef ENEMY_RESPAWN_EN
    check("respawn_mask", 32'(aliveMask), 32'(8'hFF));
    check("respawn_x", 32'(formationX), 32'(100));
    check("respawn_y", 32'(formationY), 32'(60));
    repeat (5) frame();
`else
    check("halt_mask", 32'(aliveMask), 32'(0));
    repeat (139) frame();
    check("halt_x", 32'(formationX), 32'(100));
    check("halt_alldead", 32'(allDead), 32'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
